// File: rtl/spike_event_collector_pkg.sv
// Shared definitions for the spike event collector.
//   state_t  : collector FSM encoding (COLLECT / SCAN / PRESENT)
//   sat_inc  : saturating +1 for counters up to 31 bits wide
package spike_event_collector_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Callers zero-extend their counter to 32 bits and slice the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] maxv;
    maxv = 32'((64'd1 << w) - 64'd1);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_event_collector_if.sv
// Spike input stream, window delimiter and result record of the collector.
//   master : environment side (arbiter + downstream consumer)
//   slave  : collector side
interface spike_event_collector_if #(
  parameter int NEURON_ID_W = 4,
  parameter int CNT_W       = 8,
  parameter int TOTAL_W     = 12
);
  logic                   spike_valid;
  logic [NEURON_ID_W-1:0] spike_id;
  logic                   spike_ready;
  logic                   window_end;
  logic                   result_valid;
  logic                   result_ready;
  logic [NEURON_ID_W-1:0] result_id;
  logic [CNT_W-1:0]       result_count;
  logic [TOTAL_W-1:0]     result_total;
  logic                   result_tie;
  logic                   result_none;
  logic                   window_overrun;

  modport master (
    output spike_valid, spike_id, window_end, result_ready,
    input  spike_ready, result_valid, result_id, result_count, result_total,
           result_tie, result_none, window_overrun
  );

  modport slave (
    input  spike_valid, spike_id, window_end, result_ready,
    output spike_ready, result_valid, result_id, result_count, result_total,
           result_tie, result_none, window_overrun
  );
endinterface

// File: rtl/spike_event_collector_argmax_scanner.sv
// Sequential argmax over the counter bank, one counter per cycle.
//   start_i    : pulse; scan begins next cycle at index 0
//   rd_idx_o   : counter index being read; rd_cnt_i returns its value
//   done_o     : high during the last scan cycle
//   best_*_o   : winner id/count and tie flag, held after the scan
module argmax_scanner #(
  parameter int NUM_NEURONS = 16,
  parameter int NEURON_ID_W = 4,
  parameter int CNT_W       = 8,
  localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic [IDX_W-1:0]       rd_idx_o,
  input  logic [CNT_W-1:0]       rd_cnt_i,
  output logic                   done_o,
  output logic [NEURON_ID_W-1:0] best_id_o,
  output logic [CNT_W-1:0]       best_cnt_o,
  output logic                   tie_o
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  logic                   active_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NEURON_ID_W-1:0] best_id_q;
  logic [CNT_W-1:0]       best_cnt_q;
  logic                   tie_q;
  logic [NEURON_ID_W-1:0] cur_id;

  assign cur_id = NEURON_ID_W'(idx_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q   <= 1'b0;
      idx_q      <= '0;
      best_id_q  <= '0;
      best_cnt_q <= '0;
      tie_q      <= 1'b0;
    end else if (start_i) begin
      active_q   <= 1'b1;
      idx_q      <= '0;
      best_id_q  <= '0;
      best_cnt_q <= '0;
      tie_q      <= 1'b0;
    end else if (active_q) begin
      if (rd_cnt_i > best_cnt_q) begin
        best_id_q  <= cur_id;
        best_cnt_q <= rd_cnt_i;
        tie_q      <= 1'b0;
      end else if (rd_cnt_i == best_cnt_q && rd_cnt_i != '0 && cur_id > best_id_q) begin
        // Strict > keeps the lowest index as winner; later equals only flag the tie.
        tie_q <= 1'b1;
      end
      if (idx_q == LAST) active_q <= 1'b0;
      else               idx_q    <= idx_q + 1'b1;
    end
  end

  assign rd_idx_o   = idx_q;
  assign done_o     = active_q && (idx_q == LAST);
  assign best_id_o  = best_id_q;
  assign best_cnt_o = best_cnt_q;
  assign tie_o      = tie_q;
endmodule

// File: rtl/spike_event_collector.sv
// Per-neuron spike counting over an externally delimited window, followed by
// an argmax scan and a held valid/ready result record.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : spike stream in (valid/id/ready), window_end pulse,
//                  result record out (valid/ready + id/count/total/tie/none),
//                  window_overrun pulse
module spike_event_collector
  import spike_event_collector_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int NEURON_ID_W = 4,
  parameter int CNT_W       = 8,
  parameter int TOTAL_W     = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  spike_event_collector_if.slave    bus
);
  localparam int IDX_W = $clog2(NUM_NEURONS);

  state_t                              state_q;
  logic [NUM_NEURONS-1:0][CNT_W-1:0]   cnt_q;
  logic [TOTAL_W-1:0]                  total_q;
  logic                                spike_ready_q;
  logic                                result_valid_q;
  logic                                overrun_q;

  logic                   accept, id_ok, scan_start, scan_done;
  logic [31:0]            cnt_nx, tot_nx;
  logic [IDX_W-1:0]       rd_idx;
  logic [NEURON_ID_W-1:0] best_id;
  logic [CNT_W-1:0]       best_cnt;
  logic                   best_tie;

  // spike_ready_q is only ever high in COLLECT, so it alone qualifies the handshake.
  assign accept     = bus.spike_valid && spike_ready_q;
  // Out-of-range ids are accepted but leave every counter untouched.
  assign id_ok      = {1'b0, bus.spike_id} < (NEURON_ID_W + 1)'(NUM_NEURONS);
  assign scan_start = (state_q == ST_COLLECT) && bus.window_end;
  assign cnt_nx     = sat_inc(32'(cnt_q[bus.spike_id]), CNT_W);
  assign tot_nx     = sat_inc(32'(total_q), TOTAL_W);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_COLLECT;
      cnt_q          <= '0;
      total_q        <= '0;
      spike_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      overrun_q <= bus.window_end && (state_q != ST_COLLECT);
      case (state_q)
        ST_COLLECT: begin
          if (accept && id_ok) begin
            cnt_q[bus.spike_id] <= cnt_nx[CNT_W-1:0];
            total_q             <= tot_nx[TOTAL_W-1:0];
          end
          if (bus.window_end) begin
            state_q       <= ST_SCAN;
            spike_ready_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (scan_done) begin
            state_q        <= ST_PRESENT;
            result_valid_q <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (bus.result_ready) begin
            state_q        <= ST_COLLECT;
            cnt_q          <= '0;
            total_q        <= '0;
            result_valid_q <= 1'b0;
            spike_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  argmax_scanner #(
    .NUM_NEURONS (NUM_NEURONS),
    .NEURON_ID_W (NEURON_ID_W),
    .CNT_W       (CNT_W)
  ) u_scan (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (scan_start),
    .rd_idx_o   (rd_idx),
    .rd_cnt_i   (cnt_q[rd_idx]),
    .done_o     (scan_done),
    .best_id_o  (best_id),
    .best_cnt_o (best_cnt),
    .tie_o      (best_tie)
  );

  // The scanner's registers stay put after the scan, so the record is stable
  // through PRESENT. An empty window forces the winner fields to zero.
  assign bus.spike_ready    = spike_ready_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_none    = result_valid_q && (total_q == '0);
  assign bus.result_id      = bus.result_none ? '0 : best_id;
  assign bus.result_count   = bus.result_none ? '0 : best_cnt;
  assign bus.result_tie     = bus.result_none ? 1'b0 : best_tie;
  assign bus.result_total   = total_q;
  assign bus.window_overrun = overrun_q;
endmodule

// File: tb/tb_spike_event_collector.sv
module tb_spike_event_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_event_collector_if #(.NEURON_ID_W(4), .CNT_W(8), .TOTAL_W(12)) bus ();

  spike_event_collector #(
    .NUM_NEURONS(16), .NEURON_ID_W(4), .CNT_W(8), .TOTAL_W(12)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  id;
    logic [7:0]  cnt;
    logic [11:0] tot;
    logic        tie;
    logic        none;
  } res_t;

  typedef struct {
    int   id_a; int n_a;
    int   id_b; int n_b;
    int   hold;
    res_t exp;
  } vec_t;

  res_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_spike(input int id);
    bus.spike_valid = 1'b1;
    bus.spike_id    = 4'(id);
    step();
    bus.spike_valid = 1'b0;
  endtask

  // n0 = cycles already elapsed since the window_end edge (that edge counts as 1).
  task automatic wait_result(input int n0, input int hold);
    int n;
    res_t e, snap;
    int unstable;
    n = n0;
    while (!bus.result_valid && n < 200) begin
      step();
      n++;
    end
    chk("result_latency", n, 17);
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    chk("result_id",    int'(bus.result_id),    int'(e.id));
    chk("result_count", int'(bus.result_count), int'(e.cnt));
    chk("result_total", int'(bus.result_total), int'(e.tot));
    chk("result_tie",   int'(bus.result_tie),   int'(e.tie));
    chk("result_none",  int'(bus.result_none),  int'(e.none));
    snap = '{bus.result_id, bus.result_count, bus.result_total, bus.result_tie, bus.result_none};
    unstable = 0;
    repeat (hold) begin
      step();
      if (!bus.result_valid || bus.spike_ready || bus.result_id != snap.id ||
          bus.result_count != snap.cnt || bus.result_total != snap.tot ||
          bus.result_tie != snap.tie || bus.result_none != snap.none)
        unstable++;
    end
    chk("hold_stable", unstable, 0);
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    chk("valid_drop", int'(bus.result_valid), 0);
    chk("ready_after_hs", int'(bus.spike_ready), 1);
  endtask

  task automatic close_window(input int hold);
    bus.window_end = 1'b1;
    step();
    bus.window_end = 1'b0;
    wait_result(1, hold);
  endtask

  vec_t vecs[6];
  int   n, bad;

  initial begin
    bus.spike_valid  = 1'b0;
    bus.spike_id     = '0;
    bus.window_end   = 1'b0;
    bus.result_ready = 1'b0;

    vecs[0] = '{3, 3, 5, 2, 2,  '{4'd3,  8'd3,   12'd5,   1'b0, 1'b0}};
    vecs[1] = '{2, 4, 9, 4, 2,  '{4'd2,  8'd4,   12'd8,   1'b1, 1'b0}};
    vecs[2] = '{0, 0, 0, 0, 2,  '{4'd0,  8'd0,   12'd0,   1'b0, 1'b1}};
    vecs[3] = '{7, 300, 0, 0, 10, '{4'd7, 8'd255, 12'd300, 1'b0, 1'b0}};
    vecs[4] = '{15, 2, 0, 1, 2, '{4'd15, 8'd2,   12'd3,   1'b0, 1'b0}};
    vecs[5] = '{0, 2, 15, 2, 2, '{4'd0,  8'd2,   12'd4,   1'b1, 1'b0}};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_valid",   int'(bus.result_valid),   0);
    chk("rst_ready",   int'(bus.spike_ready),    1);
    chk("rst_total",   int'(bus.result_total),   0);
    chk("rst_id",      int'(bus.result_id),      0);
    chk("rst_none",    int'(bus.result_none),    0);
    chk("rst_overrun", int'(bus.window_overrun), 0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n_a; k++) send_spike(vecs[i].id_a);
      for (int k = 0; k < vecs[i].n_b; k++) send_spike(vecs[i].id_b);
      sb_q.push_back(vecs[i].exp);
      close_window(vecs[i].hold);
    end

    // Spike in the window_end cycle counts; held spike_valid is stalled until
    // after the handshake; a window_end in SCAN only pulses window_overrun.
    send_spike(8);
    sb_q.push_back('{4'd4, 8'd1, 12'd2, 1'b1, 1'b0});
    bus.spike_valid = 1'b1;
    bus.spike_id    = 4'd4;
    bus.window_end  = 1'b1;
    step();
    bus.window_end = 1'b0;
    n = 1;
    bad = 0;
    repeat (4) begin
      step();
      n++;
      if (bus.spike_ready) bad++;
    end
    chk("scan_ready_low", bad, 0);
    bus.window_end = 1'b1;
    step();
    n++;
    bus.window_end = 1'b0;
    chk("overrun_pulse", int'(bus.window_overrun), 1);
    step();
    n++;
    chk("overrun_clear", int'(bus.window_overrun), 0);
    wait_result(n, 3);
    step();                       // the held spike is taken at this edge
    bus.spike_valid = 1'b0;
    sb_q.push_back('{4'd4, 8'd1, 12'd1, 1'b0, 1'b0});
    close_window(2);
    bad = 0;
    repeat (20) begin
      step();
      if (bus.result_valid) bad++;
    end
    chk("no_extra_result", bad, 0);
    chk("sb_drained", sb_q.size(), 0);

    // Reset in the middle of a scan discards the window.
    send_spike(6);
    send_spike(6);
    bus.window_end = 1'b1;
    step();
    bus.window_end = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midscan_rst_valid", int'(bus.result_valid), 0);
    chk("midscan_rst_ready", int'(bus.spike_ready),  1);
    chk("midscan_rst_total", int'(bus.result_total), 0);
    repeat (20) step();
    chk("midscan_rst_quiet", int'(bus.result_valid), 0);
    send_spike(1);
    sb_q.push_back('{4'd1, 8'd1, 12'd1, 1'b0, 1'b0});
    close_window(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
